// File: rtl/boot_loader_pkg.sv
// ============================================================================
// boot_loader_pkg : loader FSM states, stream constants, header check | rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR_HI = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_RUN    = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int BIDX_W     = $clog2(WORD_BYTES);

  // Empty images skip straight to the reset hold; counts beyond memory depth are rejected.
  function automatic state_e hdr_next_state(input logic [8*HDR_BYTES-1:0] n,
                                            input int                   addr_w);
    logic [32:0] limit;
    limit = 33'd1 << addr_w;
    if (n == '0) begin
      return ST_HOLD;
    end else if ({{(33 - 8*HDR_BYTES){1'b0}}, n} <= limit) begin
      return ST_DATA;
    end else begin
      return ST_ERR;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/boot_loader_byte_packer.sv
// ============================================================================
// byte_packer : MSB-first byte-to-word assembly with word-complete flag | rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module byte_packer
  import boot_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    valid_i,
  input  logic [7:0]              byte_i,
  output logic                    word_done_o,
  output logic [8*WORD_BYTES-1:0] word_o
);

  localparam int                WORD_W   = 8 * WORD_BYTES;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(WORD_BYTES - 1);

  logic [BIDX_W-1:0] idx_q, idx_d;
  logic [WORD_W-1:0] shift_q, shift_d;

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (valid_i) begin
      idx_d   = idx_q + BIDX_W'(1);
      shift_d = {shift_q[WORD_W-9:0], byte_i};
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // The final byte is merged combinationally so the word is ready on its accept cycle.
  assign word_done_o = valid_i && !clr_i && (idx_q == LAST_IDX);
  assign word_o      = {shift_q[WORD_W-9:0], byte_i};

endmodule

`default_nettype wire

// File: rtl/boot_loader.sv
// ============================================================================
// boot_loader : byte-stream program loader with CPU reset sequencing | rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int RST_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              start,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  localparam int         HDR_W     = 8 * HDR_BYTES;
  localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);

  state_e            state_q, state_d;
  logic [HDR_W-1:0]  n_q, n_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [7:0]        hold_q, hold_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rx_ready_q, rx_ready_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic              word_done;
  logic [31:0]       word;
  logic              last_word;

  assign xfer      = rx_valid && rx_ready_q;
  assign last_word = (32'(widx_q) + 32'd1) == 32'(n_q);

  byte_packer u_packer (
    .clk         (clk),
    .rst_ni      (reset),
    .clr_i       (state_q != ST_DATA),
    .valid_i     (xfer && (state_q == ST_DATA)),
    .byte_i      (rx_data),
    .word_done_o (word_done),
    .word_o      (word)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    widx_d  = widx_q;
    hold_d  = hold_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      ST_HDR_HI: begin
        if (xfer) begin
          n_d     = {rx_data, n_q[7:0]};
          state_d = ST_HDR_LO;
        end
      end
      ST_HDR_LO: begin
        if (xfer) begin
          n_d     = {n_q[HDR_W-1:8], rx_data};
          widx_d  = '0;
          hold_d  = '0;
          state_d = hdr_next_state(n_d, ADDR_W);
        end
      end
      ST_DATA: begin
        if (word_done) begin
          we_d    = 1'b1;
          addr_d  = widx_q;
          wdata_d = word;
          widx_d  = widx_q + ADDR_W'(1);
          if (last_word) begin
            hold_d  = '0;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      ST_RUN, ST_ERR: begin
        if (start) begin
          state_d = ST_HDR_HI;
        end
      end
      default: state_d = ST_HDR_HI;
    endcase

    // Status outputs are decoded from the next state so they register alongside it.
    rx_ready_d  = (state_d == ST_HDR_HI) || (state_d == ST_HDR_LO) || (state_d == ST_DATA);
    cpu_reset_d = (state_d != ST_RUN);
    done_d      = (state_d == ST_RUN);
    err_d       = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_HDR_HI;
      n_q         <= '0;
      widx_q      <= '0;
      hold_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rx_ready_q  <= 1'b1;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      widx_q      <= widx_d;
      hold_q      <= hold_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rx_ready_q  <= rx_ready_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign im_we     = we_q;
  assign im_addr   = addr_q;
  assign im_wdata  = wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_boot_loader.sv
// ============================================================================
// tb_boot_loader : scoreboard bench for the boot_loader stream loader | rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_boot_loader;

  localparam int ADDR_W   = 8;
  localparam int RST_HOLD = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              start = 1'b0;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_reset;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t sb[$];
  wr_t mon_exp;

  boot_loader #(.ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .start     (start),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%08h expected no write", im_addr, im_wdata);
      end else begin
        mon_exp = sb.pop_front();
        if (im_addr !== mon_exp.addr || im_wdata !== mon_exp.data) begin
          errors++;
          $display("FAIL write_content got (%0h,%08h) expected (%0h,%08h)",
                   im_addr, im_wdata, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    int t;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    ok = 1'b0;
    t  = 0;
    while (!ok) begin
      @(negedge clk);
      ok = (rx_ready === 1'b1);
      @(posedge clk); #1;
      t++;
      if (!ok && t >= 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout byte=%02h rx_ready=%b expected 1", b, rx_ready);
        ok = 1'b1;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_cpu_run(output int cyc);
    cyc = 0;
    while (cpu_reset === 1'b1 && cyc < RST_HOLD + 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (rx_ready !== 1'b1 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_cpu got rx_ready=%b cpu_reset=%b expected 1 1", rx_ready, cpu_reset);
    end
    checks++;
    if (im_we !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got we=%b done=%b err=%b expected 0 0 0", im_we, done, err);
    end
    checks++;
    if (im_addr !== '0 || im_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got addr=%0h data=%08h expected 0 0", im_addr, im_wdata);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_two_words();
    int cyc;
    sb.push_back(wr_t'{ADDR_W'(0), 32'h24080005});
    sb.push_back(wr_t'{ADDR_W'(1), 32'h2009FFFF});
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h24080005, 0);
    checks++;
    if (im_we !== 1'b1 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL first_write_latency got we=%b rx_ready=%b expected 1 1", im_we, rx_ready);
    end
    send_word(32'h2009FFFF, 0);
    checks++;
    if (im_we !== 1'b1 || rx_ready !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL last_write_hold got we=%b rx_ready=%b cpu_reset=%b expected 1 0 1",
               im_we, rx_ready, cpu_reset);
    end
    wait_cpu_run(cyc);
    checks++;
    if (cyc != RST_HOLD) begin
      errors++;
      $display("FAIL two_words_hold got %0d cycles expected %0d", cyc, RST_HOLD);
    end
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL two_words_run got done=%b err=%b expected 1 0", done, err);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL two_words_pending got %0d writes left expected 0", sb.size());
    end
  endtask

  task automatic test_zero_hdr();
    int cyc;
    pulse_start();
    checks++;
    if (done !== 1'b0 || cpu_reset !== 1'b1 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_from_run got done=%b cpu_reset=%b rx_ready=%b expected 0 1 1",
               done, cpu_reset, rx_ready);
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    wait_cpu_run(cyc);
    checks++;
    if (cyc != RST_HOLD) begin
      errors++;
      $display("FAIL zero_hdr_hold got %0d cycles expected %0d", cyc, RST_HOLD);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL zero_hdr_run got done=%b expected 1", done);
    end
  endtask

  task automatic test_err_hdr();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    checks++;
    if (err !== 1'b1 || rx_ready !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL err_entry got err=%b rx_ready=%b cpu_reset=%b expected 1 0 1",
               err, rx_ready, cpu_reset);
    end
    repeat (RST_HOLD + 3) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky got err=%b done=%b expected 1 0", err, done);
    end
    pulse_start();
    checks++;
    if (err !== 1'b0 || rx_ready !== 1'b1 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL err_restart got err=%b rx_ready=%b cpu_reset=%b expected 0 1 1",
               err, rx_ready, cpu_reset);
    end
  endtask

  task automatic test_full_depth();
    int          cyc;
    logic [31:0] w;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      w = $urandom;
      sb.push_back(wr_t'{ADDR_W'(i), w});
      send_word(w, 0);
    end
    wait_cpu_run(cyc);
    checks++;
    if (cyc != RST_HOLD || done !== 1'b1) begin
      errors++;
      $display("FAIL full_depth_run got cycles=%0d done=%b expected %0d 1", cyc, done, RST_HOLD);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL full_depth_pending got %0d writes left expected 0", sb.size());
    end
  endtask

  task automatic test_gappy();
    int          cyc;
    logic [31:0] w;
    pulse_start();
    send_byte(8'h00, 2);
    send_byte(8'h04, 3);
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      sb.push_back(wr_t'{ADDR_W'(i), w});
      send_word(w, 3);
    end
    wait_cpu_run(cyc);
    checks++;
    if (cyc != RST_HOLD || done !== 1'b1) begin
      errors++;
      $display("FAIL gappy_run got cycles=%0d done=%b expected %0d 1", cyc, done, RST_HOLD);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL gappy_pending got %0d writes left expected 0", sb.size());
    end
  endtask

  task automatic test_start_in_data();
    int cyc;
    pulse_start();
    checks++;
    if (done !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL start_reload got done=%b cpu_reset=%b expected 0 1", done, cpu_reset);
    end
    sb.push_back(wr_t'{ADDR_W'(0), 32'h12345678});
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    pulse_start();
    checks++;
    if (rx_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL start_in_data got rx_ready=%b done=%b err=%b expected 1 0 0",
               rx_ready, done, err);
    end
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    wait_cpu_run(cyc);
    checks++;
    if (cyc != RST_HOLD || done !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL start_ignored_result got cycles=%0d done=%b pending=%0d expected %0d 1 0",
               cyc, done, sb.size(), RST_HOLD);
    end
  endtask

  task automatic test_reset_midload();
    int cyc;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    reset = 1'b0;
    #1;
    checks++;
    if (im_we !== 1'b0 || rx_ready !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset got we=%b rx_ready=%b cpu_reset=%b done=%b expected 0 1 1 0",
               im_we, rx_ready, cpu_reset, done);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.push_back(wr_t'{ADDR_W'(0), 32'hDEADBEEF});
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'hDEADBEEF, 0);
    wait_cpu_run(cyc);
    checks++;
    if (cyc != RST_HOLD || done !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL midload_reload got cycles=%0d done=%b pending=%0d expected %0d 1 0",
               cyc, done, sb.size(), RST_HOLD);
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_hdr();
    test_err_hdr();
    test_full_depth();
    test_gappy();
    test_start_in_data();
    test_reset_midload();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_pending got %0d writes left expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
